// File: rtl/viterbi_decode.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_decode
// Purpose  : Hard-decision Viterbi decoder for the K=7, rate-1/2 code
//            (g0=133, g1=171 octal). Punctured rates arrive as rate-1/2
//            pairs with erasure flags. The decoder uses a 64-state ACS array
//            and register-exchange survivors. At end of frame it flushes the
//            survivor of state 0, so frames must be tail-terminated.
// Ports    : clk      - system clock
//            reset    - asynchronous active-high reset
//            symIn    - received pair, [0]=A (g0), [1]=B (g1)
//            eras     - per-bit erasure flags (1 = punctured)
//            symValid - symIn/eras/symLast valid
//            symLast  - final symbol of the frame
//            inReady  - symbol accepted when symValid=1
//            bitOut   - decoded bit
//            bitValid - one-cycle strobe per decoded bit
//            bitLast  - with bitValid, final bit of the frame
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_decode #(
  parameter int TB   = 48,
  parameter int PM_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] symIn,
  input  logic [1:0] eras,
  input  logic       symValid,
  input  logic       symLast,
  output logic       inReady,
  output logic       bitOut,
  output logic       bitValid,
  output logic       bitLast
);

  localparam int              c_NS      = 64;
  localparam int              c_CW      = $clog2(TB + 1);
  localparam int              c_IW      = $clog2(TB);
  localparam logic [c_CW-1:0] c_TB      = c_CW'(TB);
  localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);
  localparam logic [PM_W-1:0] c_PM_INIT = PM_W'(1) << (PM_W - 2);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [PM_W-1:0] r_pm       [c_NS];
  logic [PM_W-1:0] w_pm_nxt   [c_NS];
  logic [TB-1:0]   r_surv     [c_NS];
  logic [TB-1:0]   w_surv_nxt [c_NS];
  logic [c_CW-1:0] r_fill;
  logic [c_CW-1:0] r_pending;
  logic [c_CW-1:0] w_fill_nxt;
  logic [c_IW-1:0] w_fidx;
  logic            w_acc;
  logic            r_bitOut;
  logic            r_bitValid;
  logic            r_bitLast;

  // Hamming distance over the non-erased bits of the received pair
  function automatic logic [PM_W-1:0] f_bm(input logic [1:0] sym,
                                           input logic [1:0] er,
                                           input logic       ea,
                                           input logic       eb);
    f_bm = PM_W'(~er[0] & (sym[0] ^ ea)) + PM_W'(~er[1] & (sym[1] ^ eb));
  endfunction

  // Modulo comparison: x beats y when (x - y) is negative in two's complement
  function automatic logic f_beats(input logic [PM_W-1:0] x,
                                   input logic [PM_W-1:0] y);
    logic [PM_W-1:0] d;
    d       = x - y;
    f_beats = d[PM_W-1];
  endfunction

  // One ACS per next state. Predecessor p0 has S[5]=0 and wins ties.
  for (genvar gi = 0; gi < c_NS; gi++) begin : g_acs
    localparam logic [5:0] c_ns = 6'(gi);
    localparam logic [5:0] c_p0 = {1'b0, c_ns[5:1]};
    localparam logic [5:0] c_p1 = {1'b1, c_ns[5:1]};
    localparam logic       c_a0 = c_ns[0] ^ c_p0[1] ^ c_p0[2] ^ c_p0[4] ^ c_p0[5];
    localparam logic       c_b0 = c_ns[0] ^ c_p0[0] ^ c_p0[1] ^ c_p0[2] ^ c_p0[5];
    localparam logic       c_a1 = c_ns[0] ^ c_p1[1] ^ c_p1[2] ^ c_p1[4] ^ c_p1[5];
    localparam logic       c_b1 = c_ns[0] ^ c_p1[0] ^ c_p1[1] ^ c_p1[2] ^ c_p1[5];

    logic [PM_W-1:0] w_c0;
    logic [PM_W-1:0] w_c1;
    logic            w_sel1;

    assign w_c0   = r_pm[c_p0] + f_bm(symIn, eras, c_a0, c_b0);
    assign w_c1   = r_pm[c_p1] + f_bm(symIn, eras, c_a1, c_b1);
    assign w_sel1 = f_beats(w_c1, w_c0);

    assign w_pm_nxt[gi]   = w_sel1 ? w_c1 : w_c0;
    assign w_surv_nxt[gi] = {(w_sel1 ? r_surv[c_p1][TB-2:0] : r_surv[c_p0][TB-2:0]),
                             c_ns[0]};
  end

  assign w_acc      = symValid & inReady;
  assign w_fill_nxt = (r_fill == c_TB) ? c_TB : r_fill + c_ONE;
  assign w_fidx     = c_IW'(r_pending - c_ONE);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_acc && symLast)     w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_pending == c_ONE)   w_state_nxt = ST_RUN;
      default:                            w_state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    inReady = (r_state == ST_RUN);
  end

  // Metrics, survivors, counters and the registered bit stream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_NS; i++) begin
        r_pm[i]   <= (i == 0) ? '0 : c_PM_INIT;
        r_surv[i] <= '0;
      end
      r_fill     <= '0;
      r_pending  <= '0;
      r_bitOut   <= 1'b0;
      r_bitValid <= 1'b0;
      r_bitLast  <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_bitValid <= 1'b0;
      r_bitLast  <= 1'b0;
      if (w_acc) begin
        for (int i = 0; i < c_NS; i++) begin
          r_pm[i]   <= w_pm_nxt[i];
          r_surv[i] <= w_surv_nxt[i];
        end
        r_fill <= w_fill_nxt;
        if (symLast) begin
          // The last symbol's bits all leave during the flush, so no
          // steady-state bit is issued for it here.
          r_pending <= w_fill_nxt;
        end else if (w_fill_nxt == c_TB) begin
          r_bitValid <= 1'b1;
          r_bitOut   <= w_surv_nxt[0][TB-1];
        end
      end
    end else begin
      // Flush: walk the state-0 survivor from oldest to newest bit
      r_bitValid <= 1'b1;
      r_bitOut   <= r_surv[0][w_fidx];
      r_bitLast  <= (r_pending == c_ONE);
      r_pending  <= r_pending - c_ONE;
      if (r_pending == c_ONE) begin
        for (int i = 0; i < c_NS; i++) begin
          r_pm[i]   <= (i == 0) ? '0 : c_PM_INIT;
          r_surv[i] <= '0;
        end
        r_fill <= '0;
      end
    end
  end

  assign bitOut   = r_bitOut;
  assign bitValid = r_bitValid;
  assign bitLast  = r_bitLast;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_viterbi_decode
// Purpose  : Self-checking bench for viterbi_decode. A reference convolutional
//            encoder builds each frame from known data; the decoded stream
//            must reproduce that data, with timing and frame markers checked.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_decode;

  localparam int TB = 48;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [1:0] symIn    = 2'b00;
  logic [1:0] eras     = 2'b00;
  logic       symValid = 1'b0;
  logic       symLast  = 1'b0;
  logic       inReady;
  logic       bitOut;
  logic       bitValid;
  logic       bitLast;

  viterbi_decode #(.TB(TB), .PM_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .symIn    (symIn),
    .eras     (eras),
    .symValid (symValid),
    .symLast  (symLast),
    .inReady  (inReady),
    .bitOut   (bitOut),
    .bitValid (bitValid),
    .bitLast  (bitLast)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  bit         dat[$];     // data bits of the frame being built
  bit         exp_q[$];   // expected decoded stream
  bit         q_out[$];   // observed decoded stream
  logic [1:0] fs[$];
  logic [1:0] fe[$];
  int lastcnt    = 0;
  int last_idx   = 0;
  int first_vcyc = -1;
  int low_cnt    = 0;
  int acc48      = 0;
  int last_acc   = 0;

  // Output monitor
  always @(negedge clk) begin
    if (!reset && !inReady) low_cnt++;
    if (bitValid) begin
      q_out.push_back(bitOut);
      if (first_vcyc < 0) first_vcyc = cyc;
      if (bitLast) begin
        lastcnt++;
        last_idx = q_out.size();
      end
    end
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_frame();
    q_out.delete();
    exp_q.delete();
    first_vcyc = -1;
  endtask

  // mode 0: clean rate 1/2, 1: one bit error every 20 symbols, 2: rate 3/4
  task automatic build(input int mode);
    logic [5:0] s;
    logic       a, b, d;
    logic [1:0] sym, er;
    int         j;
    s = '0;
    fs.delete();
    fe.delete();
    for (int k = 0; k < dat.size(); k++) begin
      d   = dat[k];
      a   = d ^ s[1] ^ s[2] ^ s[4] ^ s[5];
      b   = d ^ s[0] ^ s[1] ^ s[2] ^ s[5];
      s   = {s[4:0], d};
      sym = {b, a};
      er  = 2'b00;
      if (mode == 1 && (k % 20) == 10) begin
        j      = $urandom_range(0, 1);
        sym[j] = ~sym[j];
      end
      if (mode == 2) begin
        if ((k % 3) == 1) begin er[1] = 1'b1; sym[1] = 1'b0; end
        if ((k % 3) == 2) begin er[0] = 1'b1; sym[0] = 1'b0; end
      end
      fs.push_back(sym);
      fe.push_back(er);
      exp_q.push_back(d);
    end
  endtask

  // Offer n symbols of the built frame; symLast on the frame's final symbol
  task automatic send(input bit gaps, input bit hold, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        symValid = 1'b0;
        @(negedge clk);
      end
      symValid = 1'b1;
      symIn    = fs[k];
      eras     = fe[k];
      symLast  = (k == fs.size() - 1);
      t = 0;
      while (!inReady && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!inReady) check_eq("ready_timeout", 0, 1);
      if (k == TB - 1) acc48 = cyc + 1;
      last_acc = cyc + 1;
      @(negedge clk);
    end
    if (!hold) begin
      symValid = 1'b0;
      symLast  = 1'b0;
    end
  endtask

  task automatic finish_frame(input string tag, input int nlast);
    int t;
    int nerr;
    t = 0;
    while (lastcnt < nlast && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check_eq({tag, "_nlast"}, lastcnt, nlast);
    check_eq({tag, "_nbits"}, q_out.size(), exp_q.size());
    nerr = 0;
    for (int i = 0; i < q_out.size() && i < exp_q.size(); i++)
      if (q_out[i] != exp_q[i]) nerr++;
    check_eq({tag, "_biterr"}, nerr, 0);
    check_eq({tag, "_lastpos"}, last_idx, exp_q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_bitValid", bitValid, 0);
    check_eq("rst_bitOut", bitOut, 0);
    check_eq("rst_bitLast", bitLast, 0);
    check_eq("rst_inReady", inReady, 1);
    reset = 1'b0;
    @(negedge clk);

    // All-zero frame of 100 symbols
    start_frame();
    dat.delete();
    for (int i = 0; i < 100; i++) dat.push_back(1'b0);
    build(0);
    send(1'b0, 1'b0, fs.size());
    finish_frame("zero", 1);
    check_eq("zero_first_valid", first_vcyc, acc48);

    // Impulse: all bits leave during the flush
    start_frame();
    dat.delete();
    dat.push_back(1'b1);
    for (int i = 0; i < 6; i++) dat.push_back(1'b0);
    build(0);
    send(1'b0, 1'b0, fs.size());
    finish_frame("imp", 2);
    check_eq("imp_flush_start", first_vcyc, last_acc + 1);

    // Random payload + tail with sparse single-bit errors
    start_frame();
    dat.delete();
    for (int i = 0; i < 200; i++) dat.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) dat.push_back(1'b0);
    build(1);
    send(1'b1, 1'b0, fs.size());
    finish_frame("err", 3);

    // Same payload, rate 3/4 depunctured
    start_frame();
    build(2);
    send(1'b1, 1'b0, fs.size());
    finish_frame("p34", 4);

    // Two back-to-back 60-symbol frames with symValid held high
    start_frame();
    low_cnt = 0;
    dat.delete();
    for (int i = 0; i < 54; i++) dat.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) dat.push_back(1'b0);
    build(0);
    send(1'b0, 1'b1, fs.size());
    dat.delete();
    for (int i = 0; i < 54; i++) dat.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) dat.push_back(1'b0);
    build(0);
    send(1'b0, 1'b0, fs.size());
    finish_frame("b2b", 6);
    check_eq("b2b_flush_cycles", low_cnt, 2 * TB);

    // Reset in the middle of a frame, then a clean impulse frame
    start_frame();
    dat.delete();
    for (int i = 0; i < 40; i++) dat.push_back(1'($urandom_range(0, 1)));
    build(0);
    send(1'b0, 1'b1, 30);
    symValid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check_eq("midrst_bitValid", bitValid, 0);
    check_eq("midrst_inReady", inReady, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_nlast", lastcnt, 6);
    check_eq("midrst_nbits", q_out.size(), 0);
    start_frame();
    dat.delete();
    dat.push_back(1'b1);
    for (int i = 0; i < 9; i++) dat.push_back(1'b0);
    build(0);
    send(1'b0, 1'b0, fs.size());
    finish_frame("rst_imp", 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
